regfile_wb_ctrl: RTL

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/regfile_wb_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: merges the ALU and load writeback channels onto the single
// register-file write port. Each channel owns one holding slot. A round-robin
// arbiter drains the slots, and the decode stage gets a combinational hazard
// check against every write still in flight.
// Optional feature: define WB_BYPASS_EN to add byp_valid1/2 and byp_data1/2.
// These forward the value currently on the write port to the decode stage.
module regfile_wb_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  // ALU writeback channel
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  // load writeback channel
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  // register-file write port
  output logic              WriteEnable,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [DATA_W-1:0] WriteData,
  // decode-stage hazard check
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_hit1,
  output logic              chk_hit2
`ifdef WB_BYPASS_EN
  ,
  output logic              byp_valid1,
  output logic              byp_valid2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2
`endif
);

  // holding slots: p0 = accepted, waiting for the write port
  logic              alu_vld_p0;
  logic [ADDR_W-1:0] alu_addr_p0;
  logic [DATA_W-1:0] alu_data_p0;
  logic              mem_vld_p0;
  logic [ADDR_W-1:0] mem_addr_p0;
  logic [DATA_W-1:0] mem_data_p0;

  // Set when ALU took the most recent contested grant. The reset value of 1
  // hands the first contest after reset to MEM.
  logic              last_grant_alu;

  logic              grant_alu;
  logic              grant_mem;
  logic              contested;
  logic              alu_xfer;
  logic              mem_xfer;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;

  // Round-robin arbiter: a lone full slot always wins; a contest goes to the
  // channel that did not win the previous contest.
  always_comb begin
    contested = alu_vld_p0 && mem_vld_p0;
    grant_mem = mem_vld_p0 && (!alu_vld_p0 || last_grant_alu);
    grant_alu = alu_vld_p0 && (!mem_vld_p0 || !last_grant_alu);
    alu_ready = !alu_vld_p0 || grant_alu;
    mem_ready = !mem_vld_p0 || grant_mem;
    alu_xfer  = alu_valid && alu_ready;
    mem_xfer  = mem_valid && mem_ready;
    grant_addr = grant_mem ? mem_addr_p0 : alu_addr_p0;
    grant_data = grant_mem ? mem_data_p0 : alu_data_p0;
  end

  // Slot occupancy and arbitration history. A slot granted in the same cycle
  // as a new transfer is reloaded rather than emptied, so there is no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_vld_p0     <= 1'b0;
      mem_vld_p0     <= 1'b0;
      last_grant_alu <= 1'b1;
    end else begin
      if (alu_xfer)
        alu_vld_p0 <= 1'b1;
      else if (grant_alu)
        alu_vld_p0 <= 1'b0;
      if (mem_xfer)
        mem_vld_p0 <= 1'b1;
      else if (grant_mem)
        mem_vld_p0 <= 1'b0;
      if (contested)
        last_grant_alu <= grant_alu;
    end
  end

  // Slot payloads are captured only on a transfer, so input fields driven
  // while valid is low are ignored.
  always_ff @(posedge clk) begin
    if (alu_xfer) begin
      alu_addr_p0 <= alu_addr;
      alu_data_p0 <= alu_data;
    end
    if (mem_xfer) begin
      mem_addr_p0 <= mem_addr;
      mem_data_p0 <= mem_data;
    end
  end

  // p1 = write port. A grant for register 0 frees its slot but issues no
  // write, and the previous address/data stay on the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WriteEnable <= 1'b0;
      WriteAddr   <= '0;
      WriteData   <= '0;
    end else begin
      WriteEnable <= (grant_alu || grant_mem) && (grant_addr != '0);
      if ((grant_alu || grant_mem) && (grant_addr != '0)) begin
        WriteAddr <= grant_addr;
        WriteData <= grant_data;
      end
    end
  end

  // Hazard check: a source register is pending while it sits in a slot or is
  // on the write port. Register 0 never conflicts.
  always_comb begin
    chk_hit1 = (chk_addr1 != '0) &&
               ((alu_vld_p0 && (alu_addr_p0 == chk_addr1)) ||
                (mem_vld_p0 && (mem_addr_p0 == chk_addr1)) ||
                (WriteEnable && (WriteAddr == chk_addr1)));
    chk_hit2 = (chk_addr2 != '0) &&
               ((alu_vld_p0 && (alu_addr_p0 == chk_addr2)) ||
                (mem_vld_p0 && (mem_addr_p0 == chk_addr2)) ||
                (WriteEnable && (WriteAddr == chk_addr2)));
  end

`ifdef WB_BYPASS_EN
  // Forward the value on the write port to a decode source that matches it.
  always_comb begin
    byp_valid1 = WriteEnable && (chk_addr1 != '0) && (WriteAddr == chk_addr1);
    byp_valid2 = WriteEnable && (chk_addr2 != '0) && (WriteAddr == chk_addr2);
    byp_data1  = byp_valid1 ? WriteData : '0;
    byp_data2  = byp_valid2 ? WriteData : '0;
  end
`endif

endmodule
